// File: rtl/piano_voice_sched.sv
// rtl/piano_voice_sched.sv - time-multiplexed eight-voice wavetable mixer
// One ROM read and one add per held voice per sample tick, saturated to 8 bits.
module piano_voice_sched #(
  parameter int PHASE_W    = 16,
  parameter int SAMPLE_DIV = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_keys,
  input  logic               i_cfg_we,
  input  logic [2:0]         i_cfg_idx,
  input  logic [PHASE_W-1:0] i_cfg_inc,
  output logic [5:0]         o_rom_addr,
  input  logic [7:0]         i_rom_data,
  output logic [7:0]         o_wave,
  output logic               o_wave_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PHASE_W-1:0] r_inc   [8];
  logic [PHASE_W-1:0] r_phase [8];
  logic [7:0]         r_chord;
  logic [2:0]         r_voice;
  logic signed [10:0] r_acc;
  logic [5:0]         r_rom_addr;
  logic [7:0]         r_wave;
  logic               r_wave_valid;
  logic               r_overrun;
  logic               w_tick;
  logic [7:0]         w_sat;

  assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_comb begin
    w_sat = r_acc[7:0];
    if (r_acc > 11'sd127)
      w_sat = 8'h7F;
    else if (r_acc < -11'sd128)
      w_sat = 8'h80;
  end

  // The inc write and the ACC read share a cycle safely: ACC sees the pre-write value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_chord      <= '0;
      r_voice      <= '0;
      r_acc        <= '0;
      r_rom_addr   <= '0;
      r_wave       <= '0;
      r_wave_valid <= 1'b0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_inc[i]   <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
      r_wave_valid <= 1'b0;
      if (i_cfg_we)
        r_inc[i_cfg_idx] <= i_cfg_inc;
      if (w_tick && r_state != S_IDLE)
        r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_chord <= i_keys;
            r_acc   <= '0;
            r_voice <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_chord[r_voice]) begin
            r_rom_addr <= r_phase[r_voice][PHASE_W-1 -: 6];
            r_state    <= S_WAIT;
          end else begin
            r_phase[r_voice] <= '0;
            if (r_voice == 3'd7)
              r_state <= S_DONE;
            else
              r_voice <= r_voice + 3'd1;
          end
        end
        S_WAIT: r_state <= S_ACC;
        S_ACC: begin
          r_acc            <= r_acc + {{3{i_rom_data[7]}}, i_rom_data};
          r_phase[r_voice] <= r_phase[r_voice] + r_inc[r_voice];
          if (r_voice == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_voice <= r_voice + 3'd1;
            r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          r_wave       <= w_sat;
          r_wave_valid <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_wave       = r_wave;
  assign o_wave_valid = r_wave_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_piano_voice_sched.sv
// tb/tb_piano_voice_sched.sv - scoreboard bench for piano_voice_sched
// Expected samples and their valid cycles are queued at stimulus time and popped on wave_valid.
module tb_piano_voice_sched;

  localparam int SD = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic [7:0]  keys = 8'h00;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = 3'd0;
  logic [15:0] cfg_inc = 16'h0000;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  wave;
  logic        wave_valid;
  logic        busy;
  logic        overrun;
  logic [5:0]  rom_addr2;
  logic [7:0]  wave2;
  logic        wave_valid2;
  logic        busy2;
  logic        overrun2;

  int rom_mode = 0;
  logic [7:0] rom_const = 8'h00;
  int cyc;
  int n_total = 0;
  int n_pass = 0;
  int busy_run = 0;
  int last_busy = 0;

  typedef struct {
    logic [7:0] wave;
    int         cyc;
    logic       chk;
    logic [5:0] addr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  piano_voice_sched #(.PHASE_W(16), .SAMPLE_DIV(SD)) dut (
    .i_clk(clk), .i_rst(rst), .i_keys(keys), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
    .i_cfg_inc(cfg_inc), .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_wave(wave),
    .o_wave_valid(wave_valid), .o_busy(busy), .o_overrun(overrun)
  );

  piano_voice_sched #(.PHASE_W(16), .SAMPLE_DIV(16)) dut_fast (
    .i_clk(clk), .i_rst(rst2), .i_keys(8'hFF), .i_cfg_we(1'b0), .i_cfg_idx(3'd0),
    .i_cfg_inc(16'h0000), .o_rom_addr(rom_addr2), .i_rom_data(8'h01), .o_wave(wave2),
    .o_wave_valid(wave_valid2), .o_busy(busy2), .o_overrun(overrun2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  always @(posedge clk)
    case (rom_mode)
      0:       rom_data <= {2'b00, rom_addr};
      1:       rom_data <= rom_const;
      default: rom_data <= (rom_addr == 6'd0) ? 8'h50 : 8'hB0;
    endcase

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  function automatic int next_tick(input int c);
    return c - (c % SD) + SD - 1;
  endfunction

  task automatic expect_sample(input logic [7:0] w, input int h, input int k,
                               input logic chk, input logic [5:0] a);
    exp_t e;
    e.wave = w;
    e.cyc  = next_tick(cyc) + k * SD + 10 + 2 * h;
    e.chk  = chk;
    e.addr = a;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic cfg(input int idx, input logic [15:0] val);
    cfg_we  = 1'b1;
    cfg_idx = idx[2:0];
    cfg_inc = val;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", busy, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && wave_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", wave_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wave", wave, mon_e.wave);
        check("valid_cycle", cyc, mon_e.cyc);
        if (mon_e.chk) check("rom_addr", rom_addr, mon_e.addr);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wave", wave, 0);
    check("rst_valid", wave_valid, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_overrun_fast", overrun2, 0);
    rst  = 1'b0;
    rst2 = 1'b0;

    // First tick with no keys: silent sample at SD-1+10.
    expect_sample(8'h00, 0, 0, 1'b0, 6'd0);
    drain(400);

    // Single voice, ROM returns its address.
    cfg(3, 16'h0400);
    keys = 8'h08;
    for (int k = 0; k < 4; k++) expect_sample(k[7:0], 1, k, 1'b1, k[5:0]);
    drain(4 * SD + 100);
    check("overrun_fast_set", overrun2, 1);

    // Full chord saturation, then two-key sum.
    for (int v = 0; v < 8; v++) cfg(v, 16'h0100);
    keys = 8'hFF;
    rom_mode = 1;
    rom_const = 8'h7F;
    expect_sample(8'h7F, 8, 0, 1'b0, 6'd0);
    drain(SD + 100);
    check("busy_len_full", last_busy, 25);
    rom_const = 8'h80;
    expect_sample(8'h80, 8, 0, 1'b0, 6'd0);
    drain(SD + 100);
    rom_const = 8'h50;
    keys = 8'h03;
    expect_sample(8'h7F, 2, 0, 1'b0, 6'd0);
    drain(SD + 100);
    check("busy_len_two", last_busy, 13);

    // Reset in the middle of a scan.
    keys = 8'hFF;
    wait_busy(SD + 50);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_wave", wave, 0);
    check("midrst_valid", wave_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rom_addr", rom_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Voice 0 steps ahead so that voices 0 and 1 read different samples.
    rom_mode = 2;
    keys = 8'h01;
    cfg(0, 16'h0400);
    cfg(1, 16'h0000);
    expect_sample(8'h50, 1, 0, 1'b1, 6'd0);
    drain(SD + 100);
    keys = 8'h03;
    expect_sample(8'h00, 2, 0, 1'b1, 6'd0);
    drain(SD + 100);
    keys = 8'h02;
    expect_sample(8'h50, 1, 0, 1'b1, 6'd0);
    drain(SD + 100);

    // Release and retrigger of voice 0.
    rom_mode = 0;
    keys = 8'h01;
    for (int k = 0; k < 3; k++) expect_sample(k[7:0], 1, k, 1'b1, k[5:0]);
    drain(3 * SD + 100);
    keys = 8'h00;
    expect_sample(8'h00, 0, 0, 1'b1, 6'd2);
    drain(SD + 100);
    keys = 8'h01;
    expect_sample(8'h00, 1, 0, 1'b1, 6'd0);
    wait_busy(SD + 50);
    keys = 8'hFE;
    drain(SD + 100);
    keys = 8'h00;
    @(negedge clk);

    // Increment write colliding with ACC of the same voice.
    keys = 8'h04;
    cfg(2, 16'h0400);
    begin
      int t;
      int n;
      t = next_tick(cyc);
      expect_sample(8'h00, 1, 0, 1'b1, 6'd0);
      expect_sample(8'h01, 1, 1, 1'b1, 6'd1);
      expect_sample(8'h03, 1, 2, 1'b1, 6'd3);
      n = 0;
      while (cyc != t + 5 && n < 2 * SD) begin
        @(negedge clk);
        n++;
      end
      check("reach_acc_cycle", cyc, t + 5);
      cfg(2, 16'h0800);
    end
    drain(3 * SD + 100);

    check("overrun_legal", overrun, 0);
    check("overrun_fast_sticky", overrun2, 1);
    rst2 = 1'b1;
    #1;
    check("overrun_fast_clear", overrun2, 0);
    check("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piano_voice_sched.md
# piano_voice_sched

Sequencer for the piano datapath that shares one waveform ROM and one adder between the eight key voices by time-multiplexing. On every sample tick it:

- snapshots the eight key inputs,
- walks voices 0..7 in order, reading the ROM for each held key,
- advances each held voice's phase accumulator and sums the samples,
- emits one saturated 8-bit signed sample with a valid pulse.

It sits between the key inputs and the audio output, replacing parallel per-voice ROM/adder chains.

## Interface

Parameters:
- PHASE_W, 16: phase accumulator and increment width, ≥ 6.
- SAMPLE_DIV, 256: clk cycles per sample tick, ≥ 32.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- keys, in, 8: bit i = key ti held.
- cfg_we, in, 1: write phase increment.
- cfg_idx, in, 3: voice index for the write.
- cfg_inc, in, PHASE_W: phase increment value (sets pitch).
- rom_addr, out, 6: waveform ROM address.
- rom_data, in, 8: ROM sample, two's complement; valid 1 cycle after rom_addr.
- wave, out, 8: mixed sample, two's complement.
- wave_valid, out, 1: one-cycle pulse, new wave available.
- busy, out, 1: high while state ≠ IDLE.
- overrun, out, 1: sticky; set when a tick occurs while not IDLE.

## Operation

State:
- inc[0..7] (PHASE_W bits each)
- phase[0..7] (PHASE_W bits each)
- chord (8 bits)
- voice (3 bits)
- acc (11-bit signed)
- tick counter (0..SAMPLE_DIV-1)

Tick counter:
- Free-running, wraps at SAMPLE_DIV-1.
- "tick" = counter == SAMPLE_DIV-1.

Config write:
- cfg_we=1 writes inc[cfg_idx] <= cfg_inc, in any state.
- An ACC update of the same voice in the same cycle uses the pre-write value.

FSM:
- IDLE: on tick, chord <= keys, acc <= 0, voice <= 0, go to SCAN.
- SCAN, chord[voice]=1: rom_addr <= phase[voice][PHASE_W-1:PHASE_W-6], go to WAIT.
- SCAN, chord[voice]=0: phase[voice] <= 0 (note restarts at phase 0 on next press). Then voice==7 → DONE; otherwise voice++ and stay in SCAN.
- WAIT: one cycle for ROM latency, then go to ACC.
- ACC: acc <= acc + sign-extended rom_data; phase[voice] <= phase[voice] + inc[voice] (modulo 2^PHASE_W, wraps silently). Then voice==7 → DONE; otherwise voice++ and go to SCAN.
- DONE: wave <= saturate(acc), wave_valid <= 1, go to IDLE.

Arithmetic:
- acc range is -1024..1016, so 11 bits never overflow.
- Saturation: acc > 127 → 127; acc < -128 → -128; otherwise acc[7:0].

Boundary behaviour:
- Keys changing mid-scan are ignored until the next tick.
- Tick while not IDLE: the tick is dropped and overrun <= 1. overrun clears only on rst. This cannot occur with a legal SAMPLE_DIV.
- No keys held: wave = 0 with a normal valid pulse.
- inc = 0: the voice repeats the same sample each tick.
- rom_addr holds its last value when no read is in progress.

Reset (async, any state):
- wave=0, wave_valid=0, rom_addr=0, busy=0, overrun=0.
- All phase, inc, chord and acc registers = 0; tick counter = 0; state = IDLE.
- A scan in progress is abandoned with no valid pulse.

## Timing

- Tick detected in IDLE at cycle T; SCAN begins at T+1.
- Each unheld voice costs 1 cycle (SCAN); each held voice costs 3 (SCAN, WAIT, ACC).
- With H keys held, DONE is at T+9+2H and wave_valid is high during cycle T+10+2H only. Range: T+10 (H=0) to T+26 (H=8).
- wave changes only in the cycle wave_valid rises and holds until the next DONE.
- busy is high from T+1 through the DONE cycle inclusive.
- Sample period is exactly SAMPLE_DIV cycles; first tick is SAMPLE_DIV-1 cycles after rst release.

## Test plan

- Reset: assert rst mid-scan → all outputs 0 within the same cycle; no wave_valid pulse; after release, first wave_valid at cycle SAMPLE_DIV-1+10 with wave=0.
- Single voice: inc[3]=0x0400, keys=0x08, ROM model data=addr → rom_addr sequence 0,1,2,… on successive ticks; wave equals that address; wave_valid at T+12.
- Full chord, positive saturation: all inc=0x0100, keys=0xFF, ROM constant 0x7F → wave=0x7F (acc 1016 clamped); wave_valid at T+26; busy high 25 cycles.
- Full chord, negative saturation: ROM constant 0x80 → wave=0x80 (acc -1024 clamped); mixed case with two keys giving 0x50+0x50 → 0x7F; 0x50+0xB0 → 0x00.
- Release and retrigger: hold key 0 for 3 ticks with inc=0x0400, release 1 tick, press again → phase restarts, rom_addr=0; keys toggled mid-scan do not change that sample.
- Config and overrun: cfg_we to voice 2 in the same cycle as ACC of voice 2 → old inc used, new inc used next tick; SAMPLE_DIV=16 build with keys=0xFF → overrun sets and stays 1 until rst.
